// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and constants for the ALU command controller and the ALU it drives.
package alu_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam int FUN_W  = 4;

  localparam logic [BYTE_W-1:0] CMD_OP  = 8'hCC;
  localparam logic [BYTE_W-1:0] CMD_NOP = 8'hDD;

  localparam logic [FUN_W-1:0] FUN_ADD  = 4'd0;
  localparam logic [FUN_W-1:0] FUN_SUB  = 4'd1;
  localparam logic [FUN_W-1:0] FUN_MUL  = 4'd2;
  localparam logic [FUN_W-1:0] FUN_DIV  = 4'd3;
  localparam logic [FUN_W-1:0] FUN_AND  = 4'd4;
  localparam logic [FUN_W-1:0] FUN_OR   = 4'd5;
  localparam logic [FUN_W-1:0] FUN_NAND = 4'd6;
  localparam logic [FUN_W-1:0] FUN_XOR  = 4'd7;

  typedef enum logic [3:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    ALU_RUN,
    WAIT_RES,
    TX_LO,
    TX_LO_WAIT,
    TX_HI,
    TX_HI_WAIT
  } state_t;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: parses CC/DD command frames into ALU operands, fires the ALU once
// and returns its 16-bit result to the byte transmitter, low byte first.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = BYTE_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [DATA_WIDTH-1:0]   A,
  output logic [DATA_WIDTH-1:0]   B,
  output logic [FUN_W-1:0]        ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY,
  output logic                    CTRL_BUSY
);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [FUN_W-1:0]        fun_q, fun_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    seen_q, seen_d;
  logic                    tx_fire;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      res_q   <= '0;
      tx_q    <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      res_q   <= res_d;
      tx_q    <= tx_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    res_d   = res_q;
    seen_d  = 1'b0;
    case (state_q)
      IDLE:     if (RX_D_VLD) state_d = (RX_P_DATA == CMD_OP) ? GET_A :
                                        (RX_P_DATA == CMD_NOP) ? GET_FUN : IDLE;
      GET_A:    if (RX_D_VLD) begin
                  a_d     = RX_P_DATA;
                  state_d = GET_B;
                end
      GET_B:    if (RX_D_VLD) begin
                  b_d     = RX_P_DATA;
                  state_d = GET_FUN;
                end
      GET_FUN:  if (RX_D_VLD) begin
                  fun_d   = RX_P_DATA[FUN_W-1:0];
                  state_d = ALU_RUN;
                end
      ALU_RUN:  state_d = WAIT_RES;
      WAIT_RES: if (OUT_VALID) begin
                  res_d   = ALU_OUT;
                  state_d = TX_LO;
                end
      TX_LO:    if (!TX_BUSY) state_d = TX_LO_WAIT;
      TX_HI:    if (!TX_BUSY) state_d = TX_HI_WAIT;
      // Byte is done only after the transmitter has visibly taken it (busy rose) and released it.
      TX_LO_WAIT, TX_HI_WAIT: begin
        seen_d = seen_q | TX_BUSY;
        if (seen_q && !TX_BUSY) state_d = (state_q == TX_LO_WAIT) ? TX_HI : IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_fire   = (state_q == TX_LO || state_q == TX_HI) && !TX_BUSY;
    tx_d      = !tx_fire ? tx_q :
                (state_q == TX_HI) ? res_q[2*DATA_WIDTH-1:DATA_WIDTH] : res_q[DATA_WIDTH-1:0];
    TX_D_VLD  = tx_fire;
    TX_P_DATA = tx_d;
    ALU_EN    = state_q == ALU_RUN;
    CTRL_BUSY = state_q != IDLE;
  end

  assign A       = a_q;
  assign B       = b_q;
  assign ALU_FUN = fun_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: directed plus randomized frames against a frame-level reference,
// with a behavioural ALU and a byte transmitter that raises busy after each byte.
module tb_alu_cmd_ctrl;
  import alu_ctrl_pkg::*;

  logic        CLK = 1'b0, RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  A, B, TX_P_DATA;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, TX_D_VLD, CTRL_BUSY;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_VALID = 1'b0, TX_BUSY = 1'b0;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .CTRL_BUSY(CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  int vecs = 0, errs = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0]  exp_q[$];
  int          fire_cyc[$];
  int          fire_cnt = 0, en_cnt = 0, hold_len = 0, gap = 0, hold = 0;
  bit          force_busy = 0, seen = 1, prev_fire = 0, pend = 0;
  logic [15:0] pend_v = '0;
  logic [7:0]  last_tx = '0, ref_a = '0, ref_b = '0;
  logic [3:0]  ref_fun = '0;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      FUN_ADD:  return {8'h0, a} + {8'h0, b};
      FUN_SUB:  return {8'h0, a} - {8'h0, b};
      FUN_MUL:  return {8'h0, a} * {8'h0, b};
      FUN_DIV:  return (b != 0) ? {8'h0, a / b} : 16'h0;
      FUN_AND:  return {8'h0, a & b};
      FUN_OR:   return {8'h0, a | b};
      FUN_NAND: return {8'h0, ~(a & b)};
      FUN_XOR:  return {8'h0, a ^ b};
      default:  return 16'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ALU model, transmitter model and TX-side monitor, staged within each cycle.
  initial forever begin
    @(posedge CLK);
    #1;
    OUT_VALID = pend | (!pend && $urandom_range(0, 3) == 0);
    ALU_OUT   = pend ? pend_v : 16'($urandom);
    pend      = ALU_EN;
    pend_v    = alu_f(A, B, ALU_FUN);
    #1;
    if (gap > 0) begin gap--; TX_BUSY = force_busy; end
    else if (hold > 0) begin hold--; TX_BUSY = 1'b1; end
    else TX_BUSY = force_busy;
    if (TX_BUSY) seen = 1;
    #1;
    if (!RST) begin
      last_tx = '0; gap = 0; hold = 0; seen = 1; pend = 0; prev_fire = 0;
    end else begin
      if (TX_D_VLD) begin
        chk("tx_vld_while_busy", TX_BUSY, 0);
        chk("tx_vld_back_to_back", prev_fire, 0);
        chk("tx_busy_handshake", seen, 1);
        if (exp_q.size() == 0) chk("tx_unexpected_byte", TX_P_DATA, 32'hFFFF_FFFF);
        else chk("tx_byte", TX_P_DATA, exp_q.pop_front());
        last_tx = TX_P_DATA;
        fire_cyc.push_back(cyc);
        fire_cnt++;
        gap  = $urandom_range(0, 2);
        hold = hold_len ? hold_len : $urandom_range(1, 4);
        seen = 0;
      end else chk("tx_data_stable", TX_P_DATA, last_tx);
      prev_fire = TX_D_VLD;
      if (ALU_EN) en_cnt++;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    RX_P_DATA = d;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (CTRL_BUSY === 1'b1 && n < lim) begin tick(); n++; end
    chk("idle_timeout", n < lim, 1);
  endtask

  task automatic wait_fires(input int target, input int lim);
    int n = 0;
    while (fire_cnt < target && n < lim) begin tick(); n++; end
    chk("fire_timeout", fire_cnt >= target, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_FUN"}, ALU_FUN, 0);
    chk({tag, "_EN"}, ALU_EN, 0);
    chk({tag, "_TXV"}, TX_D_VLD, 0);
    chk({tag, "_TXD"}, TX_P_DATA, 0);
    chk({tag, "_BUSY"}, CTRL_BUSY, 0);
  endtask

  task automatic apply_reset(input string tag);
    RST = 1'b0;
    #1;
    chk_reset_outs(tag);
    tick();
    tick();
    RST = 1'b1;
    exp_q.delete();
    ref_a = '0; ref_b = '0; ref_fun = '0;
    tick();
  endtask

  task automatic do_frame(input bit nop, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] f, input bit junk, input bit fb);
    int fc0, e0, r;
    logic [15:0] res;
    logic [7:0] jb;
    fc0 = fire_cnt;
    e0  = en_cnt;
    if (junk) begin
      jb = 8'($urandom);
      if (jb == CMD_OP || jb == CMD_NOP) jb = 8'h7E;
      send(jb);
      chk("idle_junk_dropped", CTRL_BUSY, 0);
    end
    force_busy = fb;
    if (nop) send(CMD_NOP);
    else begin
      send(CMD_OP);
      chk("busy_after_cmd", CTRL_BUSY, 1);
      send(a);
      send(b);
      ref_a = a;
      ref_b = b;
    end
    send(f);
    ref_fun = f[3:0];
    r = cyc;
    chk("alu_en_pulse", ALU_EN, 1);
    chk("reg_A", A, ref_a);
    chk("reg_B", B, ref_b);
    chk("reg_FUN", ALU_FUN, ref_fun);
    res = alu_f(ref_a, ref_b, ref_fun);
    exp_q.push_back(res[7:0]);
    exp_q.push_back(res[15:8]);
    if (junk) send(8'h55); else tick();
    chk("alu_en_single", ALU_EN, 0);
    if (junk) send(8'($urandom));
    if (fb) begin
      repeat (20) tick();
      chk("held_while_busy", fire_cnt, fc0);
      force_busy = 0;
      r = cyc;
      wait_fires(fc0 + 1, 10);
      if (fire_cyc.size() > fc0) chk("lo_on_busy_release", fire_cyc[fc0], r);
    end else begin
      wait_fires(fc0 + 1, 20);
      if (fire_cyc.size() > fc0) chk("lo_latency", fire_cyc[fc0], r + 2);
    end
    wait_idle(300);
    chk("bytes_per_frame", fire_cnt - fc0, 2);
    chk("en_per_frame", en_cnt - e0, 1);
    chk("expected_drained", exp_q.size(), 0);
    chk("A_held", A, ref_a);
    chk("B_held", B, ref_b);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fc0;
    tick();
    tick();
    chk_reset_outs("por");
    RST = 1'b1;
    tick();

    do_frame(0, 8'h05, 8'h03, 8'h00, 0, 0);
    do_frame(0, 8'h10, 8'h20, 8'h02, 0, 0);
    do_frame(1, 8'h00, 8'h00, 8'h01, 0, 0);
    do_frame(0, 8'h9A, 8'h0C, 8'h07, 1, 0);
    do_frame(0, 8'h33, 8'h44, 8'h05, 0, 1);

    send(CMD_OP);
    send(8'h77);
    chk("in_get_b", CTRL_BUSY, 1);
    apply_reset("rst_get_b");
    do_frame(0, 8'h0F, 8'h02, 8'h03, 0, 0);

    fc0 = fire_cnt;
    hold_len = 6;
    send(CMD_OP);
    send(8'hA5);
    send(8'h5A);
    send(8'h02);
    ref_a = 8'hA5; ref_b = 8'h5A; ref_fun = 4'h2;
    exp_q.push_back(alu_f(ref_a, ref_b, ref_fun)  & 16'h00FF);
    exp_q.push_back(alu_f(ref_a, ref_b, ref_fun) >> 8);
    wait_fires(fc0 + 2, 60);
    chk("in_tx_hi_wait", CTRL_BUSY, 1);
    apply_reset("rst_tx_hi_wait");
    hold_len = 0;
    repeat (10) tick();
    chk("no_resend_after_reset", fire_cnt, fc0 + 2);
    do_frame(0, 8'hC8, 8'h03, 8'h01, 0, 0);
    do_frame(1, 8'h00, 8'h00, 8'hF0, 0, 0);

    for (int i = 0; i < 25; i++)
      do_frame($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom),
               {4'($urandom), 4'($urandom_range(0, 7))}, 1'($urandom), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller that drives the 8-bit ALU from a byte stream and returns its result. It parses command frames arriving as received bytes, loads the operand and function registers that feed the ALU's A/B/ALU_FUN/EN inputs, captures ALU_OUT on OUT_VALID, and serializes the 16-bit result to a byte transmitter, low byte first. It sits between the serial receive/transmit path and the ALU in the system datapath.

## Interface
- DATA_WIDTH, 8: operand width and byte width of RX/TX data
- CMD_OP, 8'hCC: command byte, full frame (A, B, FUN follow)
- CMD_NOP, 8'hDD: command byte, function only (FUN follows; reuse stored A/B)

- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- A  out  DATA_WIDTH  ALU operand A (registered)
- B  out  DATA_WIDTH  ALU operand B (registered)
- ALU_FUN  out  4  ALU function code (registered)
- ALU_EN  out  1  one-cycle ALU enable pulse
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- OUT_VALID  in  1  ALU result valid
- TX_P_DATA  out  DATA_WIDTH  byte to transmitter
- TX_D_VLD  out  1  one-cycle byte-valid pulse
- TX_BUSY  in  1  transmitter busy
- CTRL_BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, TX_LO, TX_LO_WAIT, TX_HI, TX_HI_WAIT.
- IDLE: on RX_D_VLD with CMD_OP -> GET_A; with CMD_NOP -> GET_FUN; any other byte is dropped, stay IDLE.
- GET_A / GET_B: on RX_D_VLD load A / B, advance to GET_B / GET_FUN.
- GET_FUN: on RX_D_VLD load ALU_FUN <= RX_P_DATA[3:0] (upper nibble ignored) -> ALU_RUN.
- ALU_RUN: ALU_EN = 1 for exactly this cycle -> WAIT_RES.
- WAIT_RES: on OUT_VALID capture ALU_OUT into result register -> TX_LO. Waits indefinitely.
- TX_LO: when TX_BUSY = 0, pulse TX_D_VLD with TX_P_DATA = result[7:0] -> TX_LO_WAIT; otherwise hold.
- TX_LO_WAIT: wait until TX_BUSY has been seen high then low -> TX_HI.
- TX_HI / TX_HI_WAIT: same rule with result[15:8], then -> IDLE.
- RX_D_VLD in ALU_RUN through TX_HI_WAIT: byte dropped, no state effect.
- A, B, ALU_FUN hold their last loaded values across frames; only reset clears them.
- Result register is 2*DATA_WIDTH wide, no arithmetic performed here.

## Timing
- Reset (async, RST = 0): state IDLE; A, B, ALU_FUN, result = 0; ALU_EN, TX_D_VLD, CTRL_BUSY = 0; TX_P_DATA = 0. Reset mid-frame or mid-transmit aborts immediately; no partial byte re-sent after release.
- FUN byte strobed in cycle N: ALU_EN high in N+1; ALU registers result, OUT_VALID high in N+2; result captured at end of N+2; TX_D_VLD (low byte) in N+3 if TX_BUSY = 0.
- TX_D_VLD is never high on two consecutive cycles and never high while TX_BUSY = 1.
- TX_P_DATA held stable from the TX_D_VLD cycle until the next TX_D_VLD.
- Back-to-back frames: next command byte is accepted the cycle after TX_HI_WAIT exits.
- OUT_VALID outside WAIT_RES is ignored.

## Structure
- Package alu_ctrl_pkg: state enum, CMD_OP/CMD_NOP constants, ALU_FUN width (4), function-code constants shared with the ALU.
- Single module; the two-byte TX sequencing is kept in the main FSM, no sub-module.

## Test plan
- Reset then frame CC,05,03,00 -> A=5, B=3, FUN=0, one ALU_EN pulse; with ALU model returning 0x0008, TX bytes 08 then 00.
- Frame CC,10,20,02 (multiply, result 0x0200) -> TX 00 then 02; CTRL_BUSY high from CC until after second byte.
- After previous frame, DD,01 -> A=10, B=20 unchanged, FUN=1, ALU_EN pulse, result 0xFFF0 sent F0, FF.
- Junk byte 7E in IDLE, then extra bytes 55 during WAIT_RES/TX states -> no state change from either; frame completes normally.
- TX_BUSY held high 20 cycles during TX_LO -> TX_D_VLD stays low, fires the first cycle TX_BUSY = 0; high byte only after busy rise and fall.
- RST asserted in GET_B and again in TX_HI_WAIT -> all outputs zero same cycle, IDLE after release, next CC frame processed correctly.
